core_nco_clkgen: RTL and testbench

Multi-channel, runtime-programmable digital clock generator that follows the fixed-ratio PLL in the core clock subsystem. It runs on the PLL output clock and produces NUM_CH phase-related clock-level outputs and single-cycle tick strobes for the chopper PWM carriers. Each channel has its own frequency, phase offset and duty cycle. Settings change atomically on a commit, and a lock indicator reports when the outputs are valid.

---
 rtl/core_nco_clkgen_pkg.sv | 20 ++
 rtl/core_nco_ch.sv | 84 ++++++++
 rtl/core_nco_clkgen.sv | 98 +++++++++
 tb/tb_core_nco_clkgen.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_nco_clkgen_pkg.sv
// Shared definitions for the NCO clock generator: config select codes,
// lock FSM states and the settle-counter sizing helper.
package core_nco_clkgen_pkg;

  localparam logic [1:0] CFG_FREQ  = 2'd0;
  localparam logic [1:0] CFG_PHASE = 2'd1;
  localparam logic [1:0] CFG_DUTY  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Counter wide enough to hold 0..SETTLE_CYCLES
  function automatic int settle_cnt_width(input int settle_cycles);
    return (settle_cycles < 1) ? 1 : $clog2(settle_cycles + 1);
  endfunction

endpackage

// File: rtl/core_nco_ch.sv
// One NCO channel: shadow/active freq, phase and duty, the phase
// accumulator and the registered clock-level and tick outputs.
module core_nco_ch #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             commit,
  input  logic             we,
  input  logic [1:0]       sel,
  input  logic [ACC_W-1:0] data,
  output logic             outclk,
  output logic             tick
);
  import core_nco_clkgen_pkg::*;

  logic [ACC_W-1:0] sh_freq_reg, sh_phase_reg, sh_duty_reg;
  logic [ACC_W-1:0] sh_freq_next, sh_phase_next, sh_duty_next;
  logic [ACC_W-1:0] freq_reg, phase_reg, duty_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] lead;
  logic             outclk_reg, tick_reg;

  // A write in the commit cycle must be visible to the commit, so the
  // commit copies the post-write shadow values.
  always_comb begin
    sh_freq_next  = sh_freq_reg;
    sh_phase_next = sh_phase_reg;
    sh_duty_next  = sh_duty_reg;
    if (we) begin
      case (sel)
        CFG_FREQ:  sh_freq_next  = data;
        CFG_PHASE: sh_phase_next = data;
        CFG_DUTY:  sh_duty_next  = data;
        default:   ;
      endcase
    end
  end

  assign sum      = {1'b0, acc_reg} + {1'b0, freq_reg};
  assign acc_next = sum[ACC_W-1:0];
  assign lead     = acc_next + phase_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_freq_reg  <= '0;
      sh_phase_reg <= '0;
      sh_duty_reg  <= '0;
      freq_reg     <= '0;
      phase_reg    <= '0;
      duty_reg     <= '0;
      acc_reg      <= '0;
      outclk_reg   <= 1'b0;
      tick_reg     <= 1'b0;
    end else begin
      sh_freq_reg  <= sh_freq_next;
      sh_phase_reg <= sh_phase_next;
      sh_duty_reg  <= sh_duty_next;
      if (commit) begin
        freq_reg   <= sh_freq_next;
        phase_reg  <= sh_phase_next;
        duty_reg   <= sh_duty_next;
        acc_reg    <= '0;
        tick_reg   <= 1'b0;
        outclk_reg <= run && (sh_phase_next < sh_duty_next);
      end else if (run) begin
        acc_reg    <= acc_next;
        tick_reg   <= sum[ACC_W];
        outclk_reg <= (lead < duty_reg);
      end else begin
        // Disabled: accumulator holds so the phase resumes on re-enable
        tick_reg   <= 1'b0;
        outclk_reg <= 1'b0;
      end
    end
  end

  assign outclk = outclk_reg;
  assign tick   = tick_reg;

endmodule

// File: rtl/core_nco_clkgen.sv
// Multi-channel NCO clock generator: lock FSM with settle counter,
// config channel decode and NUM_CH generated NCO channels.
module core_nco_clkgen #(
  parameter int NUM_CH        = 4,
  parameter int ACC_W         = 32,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [ACC_W-1:0]  cfg_data,
  input  logic              cfg_commit,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);
  import core_nco_clkgen_pkg::*;

  localparam int               CNT_W    = settle_cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Any commit while running restarts the settle window
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = SETTLE;
          cnt_next   = '0;
        end
        SETTLE: begin
          if (cfg_commit) begin
            cnt_next = '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = LOCKED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        LOCKED: begin
          if (cfg_commit) begin
            state_next = SETTLE;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    locked = (state_reg == LOCKED);
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic ch_we;
    assign ch_we = cfg_we && (cfg_ch == 3'(gi));

    core_nco_ch #(
      .ACC_W (ACC_W)
    ) u_ch (
      .clk    (refclk),
      .rst    (rst),
      .run    (enable),
      .commit (cfg_commit),
      .we     (ch_we),
      .sel    (cfg_sel),
      .data   (cfg_data),
      .outclk (outclk[gi]),
      .tick   (tick[gi])
    );
  end

endmodule

// File: tb/tb_core_nco_clkgen.sv
// Self-checking bench for core_nco_clkgen: directed scenarios plus random
// traffic, checked against an arithmetic model of the channel behaviour.
module tb_core_nco_clkgen;
  localparam int NUM_CH = 4;
  localparam int ACC_W  = 32;
  localparam int SETTLE = 16;
  localparam longint unsigned MODV = 64'd1 << ACC_W;

  logic              refclk = 1'b0;
  logic              rst, enable, cfg_we, cfg_commit;
  logic [2:0]        cfg_ch;
  logic [1:0]        cfg_sel;
  logic [ACC_W-1:0]  cfg_data;
  logic [NUM_CH-1:0] outclk, tick;
  logic              locked;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: [ch][0=freq,1=phase,2=duty]
  longint unsigned m_sh [NUM_CH][3];
  longint unsigned m_act[NUM_CH][3];
  longint unsigned m_acc[NUM_CH];
  bit m_out [NUM_CH];
  bit m_tick[NUM_CH];
  bit m_locked, m_was_en;
  int m_since;

  core_nco_clkgen #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .refclk(refclk), .rst(rst), .enable(enable), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .outclk(outclk), .tick(tick), .locked(locked)
  );

  always #5 refclk = ~refclk;

  function automatic logic [2*NUM_CH:0] exp_vec();
    logic [2*NUM_CH:0] v;
    v = '0;
    v[2*NUM_CH] = m_locked;
    for (int c = 0; c < NUM_CH; c++) begin
      v[NUM_CH + c] = m_tick[c];
      v[c]          = m_out[c];
    end
    return v;
  endfunction

  task automatic model_edge();
    longint unsigned s;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < 3; k++) begin
          m_sh[c][k]  = 0;
          m_act[c][k] = 0;
        end
        m_acc[c] = 0; m_out[c] = 0; m_tick[c] = 0;
      end
      m_locked = 0; m_was_en = 0; m_since = 0;
    end else begin
      if (cfg_we && cfg_ch < NUM_CH && cfg_sel != 2'd3)
        m_sh[cfg_ch][cfg_sel] = longint'(cfg_data);
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_commit) begin
          for (int k = 0; k < 3; k++) m_act[c][k] = m_sh[c][k];
          m_acc[c]  = 0;
          m_tick[c] = 0;
          m_out[c]  = enable && (m_act[c][1] < m_act[c][2]);
        end else if (enable) begin
          s         = m_acc[c] + m_act[c][0];
          m_tick[c] = (s >= MODV);
          m_acc[c]  = s % MODV;
          m_out[c]  = ((m_acc[c] + m_act[c][1]) % MODV) < m_act[c][2];
        end else begin
          m_tick[c] = 0;
          m_out[c]  = 0;
        end
      end
      if (!enable) begin
        m_locked = 0; m_was_en = 0; m_since = 0;
      end else begin
        if (!m_was_en || cfg_commit) m_since = 0;
        else if (m_since < SETTLE) m_since++;
        m_was_en = 1;
        m_locked = (m_since >= SETTLE);
      end
    end
  endtask

  // Advance one edge, update the model, then settle before sampling
  task automatic step();
    @(posedge refclk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit we, input int ch, input int sel,
                       input logic [ACC_W-1:0] data, input bit commit);
    cfg_we     = we;
    cfg_ch     = 3'(ch);
    cfg_sel    = 2'(sel);
    cfg_data   = data;
    cfg_commit = commit;
  endtask

  task automatic test_reset();
    int k;
    rst = 1; enable = 0; drive(0, 0, 0, '0, 0);
    repeat (2) step();
    n_checks++;
    if ({locked, tick, outclk} !== '0) begin
      n_fails++;
      $display("FAIL reset_state: got %h want 0", {locked, tick, outclk});
    end
    rst = 0; enable = 1;
    k = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      n_checks++;
      if ({locked, tick, outclk} !== exp_vec()) begin
        n_fails++;
        $display("FAIL reset_model: got %h want %h", {locked, tick, outclk}, exp_vec());
      end
      if (locked === 1'b1 && k < 0) k = i;
    end
    n_checks++;
    if (k != SETTLE) begin
      n_fails++;
      $display("FAIL reset_lock_latency: got %0d want %0d", k, SETTLE);
    end
  endtask

  task automatic test_align();
    logic [ACC_W-1:0] wr_data [6];
    int wr_ch [6];
    int wr_sel[6];
    logic [7:0] seq0, seq1, tk0, tk1;
    wr_ch  = '{0, 0, 0, 1, 1, 1};
    wr_sel = '{0, 1, 2, 0, 1, 2};
    wr_data = '{32'h4000_0000, 32'h0, 32'h8000_0000,
                32'h4000_0000, 32'h4000_0000, 32'h8000_0000};
    for (int i = 0; i < 6; i++) begin
      drive(1, wr_ch[i], wr_sel[i], wr_data[i], i == 5);
      step();
      n_checks++;
      if ({locked, tick, outclk} !== exp_vec()) begin
        n_fails++;
        $display("FAIL align_write%0d: got %h want %h", i, {locked, tick, outclk}, exp_vec());
      end
    end
    drive(0, 0, 0, '0, 0);
    // Capture from the commit edge onward
    seq0 = '0; seq1 = '0; tk0 = '0; tk1 = '0;
    seq0[7] = outclk[0]; seq1[7] = outclk[1]; tk0[7] = tick[0]; tk1[7] = tick[1];
    for (int i = 6; i >= 0; i--) begin
      step();
      n_checks++;
      if ({locked, tick, outclk} !== exp_vec()) begin
        n_fails++;
        $display("FAIL align_model: got %h want %h", {locked, tick, outclk}, exp_vec());
      end
      seq0[i] = outclk[0]; seq1[i] = outclk[1]; tk0[i] = tick[0]; tk1[i] = tick[1];
    end
    n_checks++;
    if (seq0 !== 8'b1100_1100) begin
      n_fails++; $display("FAIL align_ch0_pattern: got %b want 11001100", seq0);
    end
    n_checks++;
    if (seq1 !== 8'b1001_1001) begin
      n_fails++; $display("FAIL align_ch1_pattern: got %b want 10011001", seq1);
    end
    n_checks++;
    if (tk0 !== 8'b0000_1000 || tk1 !== tk0) begin
      n_fails++; $display("FAIL align_ticks: got %b/%b want 00001000/00001000", tk0, tk1);
    end
  endtask

  task automatic test_shadow();
    int k;
    drive(1, 0, 0, 32'h2000_0000, 0);
    step();
    drive(0, 0, 0, '0, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if ({locked, tick, outclk} !== exp_vec()) begin
        n_fails++;
        $display("FAIL shadow_hold: got %h want %h", {locked, tick, outclk}, exp_vec());
      end
    end
    drive(1, 0, 0, 32'h1000_0000, 1);
    step();
    drive(0, 0, 0, '0, 0);
    n_checks++;
    if (locked !== 1'b0 || outclk[0] !== 1'b1 || tick !== '0) begin
      n_fails++;
      $display("FAIL shadow_commit_edge: got locked=%b out0=%b tick=%b want 0/1/0",
               locked, outclk[0], tick);
    end
    k = -1;
    for (int i = 1; i < 40; i++) begin
      step();
      n_checks++;
      if ({locked, tick, outclk} !== exp_vec()) begin
        n_fails++;
        $display("FAIL shadow_model: got %h want %h", {locked, tick, outclk}, exp_vec());
      end
      if (locked === 1'b1 && k < 0) k = i;
    end
    n_checks++;
    if (k != SETTLE) begin
      n_fails++;
      $display("FAIL shadow_relock: got %0d want %0d", k, SETTLE);
    end
  endtask

  task automatic test_ignored();
    bit bad;
    drive(1, 7, 0, 32'hdead_beef, 0); step();
    drive(1, 1, 3, 32'h1234_5678, 0); step();
    drive(1, 2, 0, 32'h0, 0);         step();
    drive(1, 2, 1, 32'h0, 0);         step();
    drive(1, 2, 2, 32'd5, 1);         step();
    drive(0, 0, 0, '0, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if ({locked, tick, outclk} !== exp_vec()) begin
        n_fails++;
        $display("FAIL ignored_model: got %h want %h", {locked, tick, outclk}, exp_vec());
      end
      if (outclk[2] !== 1'b1 || tick[2] !== 1'b0) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fails++;
      $display("FAIL freq0_static: got out2=%b tick2=%b want 1/0", outclk[2], tick[2]);
    end
  endtask

  task automatic test_enable_toggle();
    int k;
    bit bad;
    repeat (3) step();
    enable = 0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({locked, tick, outclk} !== exp_vec()) begin
        n_fails++;
        $display("FAIL disable_model: got %h want %h", {locked, tick, outclk}, exp_vec());
      end
      if ({locked, tick, outclk} !== '0) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fails++; $display("FAIL disable_low: got %h want 0", {locked, tick, outclk});
    end
    enable = 1;
    k = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      n_checks++;
      if ({locked, tick, outclk} !== exp_vec()) begin
        n_fails++;
        $display("FAIL reenable_model: got %h want %h", {locked, tick, outclk}, exp_vec());
      end
      if (locked === 1'b1 && k < 0) k = i;
    end
    n_checks++;
    if (k != SETTLE) begin
      n_fails++; $display("FAIL reenable_lock: got %0d want %0d", k, SETTLE);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 3) == 0, int'($urandom % 8), int'($urandom % 4),
            $urandom, ($urandom % 40) == 0);
      if (($urandom % 80) == 0) enable = ~enable;
      rst = (($urandom % 700) == 0);
      step();
      n_checks++;
      if ({locked, tick, outclk} !== exp_vec()) begin
        n_fails++;
        $display("FAIL random_c%0d: got %h want %h", i, {locked, tick, outclk}, exp_vec());
      end
    end
    rst = 0; enable = 1; drive(0, 0, 0, '0, 0);
  endtask

  task automatic test_reset_mid_run();
    int k;
    repeat (5) step();
    rst = 1;
    step();
    n_checks++;
    if ({locked, tick, outclk} !== '0) begin
      n_fails++; $display("FAIL midrun_reset: got %h want 0", {locked, tick, outclk});
    end
    rst = 0;
    k = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      n_checks++;
      if ({locked, tick, outclk} !== exp_vec()) begin
        n_fails++;
        $display("FAIL midrun_model: got %h want %h", {locked, tick, outclk}, exp_vec());
      end
      if (locked === 1'b1 && k < 0) k = i;
    end
    n_checks++;
    if (k != SETTLE) begin
      n_fails++; $display("FAIL midrun_relock: got %0d want %0d", k, SETTLE);
    end
  endtask

  initial begin
    test_reset();
    test_align();
    test_shadow();
    test_ignored();
    test_enable_toggle();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
